sc_eval_ctrl: RTL and testbench

Sequencer that drives one combinational stochastic-computing core (the canonical-form AND-OR network or equivalent) through a full bitstream evaluation. It accepts a job of NUM_VARS binary probabilities and generates the constant and variable input bits each cycle for 2**PREC cycles. It counts the ones on every core output and returns the binary counts over a valid/ready handshake. It sits between the binary-domain host logic and the SC core, and owns the core for the whole evaluation.

---
 rtl/sc_eval_pkg.sv | 41 ++++
 rtl/sc_sng.sv | 31 +++
 rtl/sc_eval_ctrl.sv | 116 +++++++++++
 tb/tb_sc_eval_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_eval_pkg
//  Description : Shared types and helpers for the stochastic-computing
//                evaluation sequencer: FSM state encoding, bit reversal used
//                to spread the counter, and per-variable decorrelation masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_eval_pkg;

    // Widest precision the helpers are written for.
    localparam int c_max_prec = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reverse the low 'prec' bits of x; bits at or above prec come out zero.
    function automatic logic [c_max_prec-1:0] bitrev(input logic [c_max_prec-1:0] x,
                                                     input int                    prec);
        logic [c_max_prec-1:0] r;
        r = '0;
        for (int i = 0; i < c_max_prec; i++) begin
            if (i < prec) begin
                r[4'(i)] = x[4'(prec - 1 - i)];
            end
        end
        return r;
    endfunction

    // XOR mask decorrelating the generators; index 0 gets mask 0.
    function automatic logic [c_max_prec-1:0] var_mask(input int idx, input int prec);
        int m;
        m = (idx * 32'hA5) & ((32'd1 << prec) - 32'd1);
        return m[c_max_prec-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_sng.sv
`default_nettype none
// ============================================================================
//  Module      : sc_sng
//  Description : Stochastic number generator. Compares a bit-reversed,
//                masked copy of the run counter with the probability
//                numerator. Because the random number visits every PREC-bit
//                value once per run, the bit is high exactly 'value' times.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_sng #(
    parameter int PREC  = 4,
    parameter int INDEX = 0
) (
    input  logic [PREC:0]   value,
    input  logic [PREC-1:0] cnt,
    output logic            sng_out
);
    import sc_eval_pkg::*;

    localparam logic [PREC-1:0] c_mask = PREC'(var_mask(INDEX, PREC));

    logic [PREC-1:0] w_rn;

    // Pseudo-random sample: bit-reversed counter decorrelated by the mask.
    always_comb begin
        w_rn    = PREC'(bitrev(c_max_prec'(cnt), PREC)) ^ c_mask;
        sng_out = ({1'b0, w_rn} < value);
    end

endmodule
`default_nettype wire

// File: rtl/sc_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sc_eval_ctrl
//  Description : Drives a combinational SC core through one full bitstream
//                of 2**PREC cycles, counts ones on each core output and
//                returns the counts over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_eval_ctrl #(
    parameter int NUM_CONSTS  = 2,
    parameter int NUM_VARS    = 2,
    parameter int NUM_OUTPUTS = 2,
    parameter int PREC        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_VARS*(PREC+1)-1:0]  in_values,
    input  logic                          abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_OUTPUTS*(PREC+1)-1:0] out_counts,
    output logic                          core_en,
    output logic [NUM_CONSTS-1:0]         core_const,
    output logic [NUM_VARS-1:0]           core_var,
    input  logic [NUM_OUTPUTS-1:0]        core_out
);
    import sc_eval_pkg::*;

    localparam int              c_w        = PREC + 1;
    localparam logic [PREC-1:0] c_cnt_last = '1;

    state_t                             r_state;
    logic [PREC-1:0]                    r_cnt;
    logic [NUM_VARS-1:0][c_w-1:0]       r_values;
    logic [NUM_OUTPUTS-1:0][c_w-1:0]    r_acc;
    logic [NUM_OUTPUTS-1:0][c_w-1:0]    w_acc_next;
    logic [NUM_VARS-1:0]                w_sng;

    // One generator per variable, all stepping on the shared counter.
    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_sng
            sc_sng #(
                .PREC  (PREC),
                .INDEX (gi)
            ) u_sng (
                .value   (r_values[gi]),
                .cnt     (r_cnt),
                .sng_out (w_sng[gi])
            );
        end
    endgenerate

    // Next accumulator value: add this cycle's core output bit.
    generate
        for (genvar gk = 0; gk < NUM_OUTPUTS; gk++) begin : g_acc
            assign w_acc_next[gk] = r_acc[gk] + c_w'(core_out[gk]);
        end
    endgenerate

    assign out_counts = r_acc;
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);

    // Core inputs carry a live sample only while running; forced low otherwise.
    always_comb begin
        core_en    = (r_state == RUN);
        core_const = '0;
        core_var   = '0;
        if (r_state == RUN) begin
            core_const = r_cnt[NUM_CONSTS-1:0];
            core_var   = w_sng;
        end
    end

    // Sequencer: accept job, sweep the bitstream, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_values <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_values <= in_values;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_acc <= w_acc_next;
                        if (r_cnt == c_cnt_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_eval_ctrl
//  Description : Directed bench for sc_eval_ctrl with a stub core:
//                out[0] = var[0], out[1] = (const == 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_eval_ctrl;
    localparam int NC = 2;
    localparam int NV = 2;
    localparam int NO = 2;
    localparam int PR = 4;
    localparam int W  = PR + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NV*W-1:0] in_values;
    logic            abort;
    logic            out_valid;
    logic            out_ready;
    logic [NO*W-1:0] out_counts;
    logic            core_en;
    logic [NC-1:0]   core_const;
    logic [NV-1:0]   core_var;
    logic [NO-1:0]   core_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign core_out = {(core_const == 2'd3), core_var[0]};

    sc_eval_ctrl #(
        .NUM_CONSTS  (NC),
        .NUM_VARS    (NV),
        .NUM_OUTPUTS (NO),
        .PREC        (PR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_values  (in_values),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_counts (out_counts),
        .core_en    (core_en),
        .core_const (core_const),
        .core_var   (core_var),
        .core_out   (core_out)
    );

    // Offer a job and return once it has been accepted on a rising edge.
    task automatic accept(input logic [4:0] v0, input logic [4:0] v1,
                          input bit with_abort, output bit ok);
        @(negedge clk);
        in_values = {v1, v0};
        in_valid  = 1'b1;
        abort     = with_abort;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    // Follow a run cycle by cycle after acceptance until out_valid appears.
    task automatic observe(output int en_cnt, output int lat, output bit const_ok,
                           output logic [4:0] c0, output logic [4:0] c1);
        en_cnt   = 0;
        lat      = -1;
        const_ok = 1'b1;
        c0       = '0;
        c1       = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (core_en) begin
                if (core_const !== 2'(en_cnt % 4)) const_ok = 1'b0;
                en_cnt++;
            end
            if (out_valid) begin
                lat = c;
                c0  = out_counts[4:0];
                c1  = out_counts[9:5];
                break;
            end
        end
    endtask

    // Take the result and report in_ready one cycle later.
    task automatic take_result(output logic ready_after);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        ready_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en got %b want 0", core_en); end
        checks++; if (out_counts !== 10'd0) begin errors++; $display("FAIL reset_out_counts got %h want 0", out_counts); end
        checks++; if (core_const !== 2'd0 || core_var !== 2'd0) begin errors++; $display("FAIL reset_core_in got %b/%b want 0/0", core_const, core_var); end
    endtask

    task automatic test_loopback();
        logic [4:0] vals [3];
        bit         ok;
        int         en_cnt, lat;
        bit         cok;
        logic [4:0] c0, c1;
        logic       rdy;
        vals[0] = 5'd0; vals[1] = 5'd7; vals[2] = 5'd16;
        for (int j = 0; j < 3; j++) begin
            accept(vals[j], 5'd5, 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL loop_accept got 0 want 1"); end
            observe(en_cnt, lat, cok, c0, c1);
            checks++; if (c0 !== vals[j]) begin errors++; $display("FAIL loop_count0 got %0d want %0d", c0, vals[j]); end
            checks++; if (en_cnt != 16) begin errors++; $display("FAIL loop_core_en_cycles got %0d want 16", en_cnt); end
            checks++; if (lat != 17) begin errors++; $display("FAIL loop_latency got %0d want 17", lat); end
            take_result(rdy);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL loop_ready_after got %b want 1", rdy); end
        end
    endtask

    task automatic test_const();
        bit         ok;
        int         en_cnt, lat;
        bit         cok;
        logic [4:0] c0, c1;
        logic       rdy;
        accept(5'd3, 5'd11, 1'b0, ok);
        observe(en_cnt, lat, cok, c0, c1);
        checks++; if (c1 !== 5'd4) begin errors++; $display("FAIL const_count1 got %0d want 4", c1); end
        checks++; if (cok !== 1'b1) begin errors++; $display("FAIL const_sequence got %b want 1", cok); end
        checks++; if (c0 !== 5'd3) begin errors++; $display("FAIL const_count0 got %0d want 3", c0); end
        take_result(rdy);
    endtask

    task automatic test_backpressure();
        bit         ok;
        int         en_cnt, lat;
        bit         cok;
        logic [4:0] c0, c1;
        logic       rdy;
        bit         stable;
        int         seen_en;
        stable  = 1'b1;
        seen_en = 0;
        accept(5'd10, 5'd0, 1'b0, ok);
        observe(en_cnt, lat, cok, c0, c1);
        checks++; if (c0 !== 5'd10) begin errors++; $display("FAIL bp_count0 got %0d want 10", c0); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            abort    = ~i[0];
            @(negedge clk);
            if (out_counts !== {c1, c0} || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold got %h/%b/%b want %h/1/0", out_counts, out_valid, in_ready, {c1, c0}); end
        take_result(rdy);
        checks++; if (rdy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b ov=%b want 1/0", rdy, out_valid); end
        repeat (4) begin
            @(negedge clk);
            if (core_en) seen_en++;
        end
        checks++; if (seen_en != 0) begin errors++; $display("FAIL bp_no_queue got %0d en cycles want 0", seen_en); end
    endtask

    task automatic test_abort();
        bit         ok;
        int         en_cnt, lat;
        bit         cok;
        logic [4:0] c0, c1;
        logic       rdy;
        bit         ov_seen;
        ov_seen = 1'b0;
        // abort together with in_valid in IDLE still accepts the job
        accept(5'd12, 5'd0, 1'b1, ok);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        @(negedge clk);
        checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL abort_accepted got core_en=%b want 1", core_en); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL abort_idle got rdy=%b en=%b want 1/0", in_ready, core_en); end
        repeat (25) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        checks++; if (ov_seen) begin errors++; $display("FAIL abort_no_result got out_valid=1 want 0"); end
        accept(5'd9, 5'd0, 1'b0, ok);
        observe(en_cnt, lat, cok, c0, c1);
        checks++; if (c0 !== 5'd9) begin errors++; $display("FAIL abort_next_count0 got %0d want 9", c0); end
        take_result(rdy);
    endtask

    task automatic test_mid_reset();
        bit         ok;
        int         en_cnt, lat;
        bit         cok;
        logic [4:0] c0, c1;
        logic       rdy;
        accept(5'd4, 5'd0, 1'b0, ok);
        for (int c = 1; c <= 10; c++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL mrst_state got rdy=%b ov=%b en=%b want 1/0/0", in_ready, out_valid, core_en); end
        checks++; if (out_counts !== 10'd0) begin errors++; $display("FAIL mrst_counts got %h want 0", out_counts); end
        accept(5'd16, 5'd0, 1'b0, ok);
        observe(en_cnt, lat, cok, c0, c1);
        checks++; if (c0 !== 5'd16) begin errors++; $display("FAIL mrst_count0 got %0d want 16", c0); end
        checks++; if (c1 !== 5'd4) begin errors++; $display("FAIL mrst_count1 got %0d want 4", c1); end
        take_result(rdy);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_values = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_loopback();
        test_const();
        test_backpressure();
        test_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
